// File: rtl/vga_timing_gen.sv
// Raster timing source for 640x480@60 VGA: pixel-rate enable, h/v counters, syncs, bright, frame tick.
// Optional macro VGA_SYNC_DELAY_EN delays hSync/vSync by one pixel period to match a registered sprite ROM.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       V_TICK   = 10'(V_VIS);

  // 11-bit bounds so a sync end equal to 1024 still compares correctly
  localparam logic [10:0] H_VIS_B  = 11'(H_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_B  = 11'(V_VIS);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_en;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             r_bright;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_tick;

  logic [DIV_W-1:0] w_div_next;
  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic [10:0]      w_h_ext;
  logic [10:0]      w_v_ext;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_div_next = r_div_cnt + 1'b1;
    w_h_next   = r_h;
    w_v_next   = r_v;
    if (r_div_cnt == DIV_LAST) begin
      w_div_next = '0;
    end
    if (r_pix_en) begin
      if (r_h == H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        w_h_next = r_h + 10'd1;
      end
    end
    w_h_ext = {1'b0, w_h_next};
    w_v_ext = {1'b0, w_v_next};
  end

  // Decodes use the next counter values so they line up with hCount/vCount after the edge.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt    <= '0;
      r_pix_en     <= 1'b0;
      r_h          <= H_LAST;
      r_v          <= V_LAST;
      r_bright     <= 1'b0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_div_cnt    <= w_div_next;
      r_pix_en     <= (w_div_next == DIV_LAST);
      r_h          <= w_h_next;
      r_v          <= w_v_next;
      r_bright     <= (w_h_ext < H_VIS_B) && (w_v_ext < V_VIS_B);
      r_hsync      <= !((w_h_ext >= HS_START) && (w_h_ext < HS_END));
      r_vsync      <= !((w_v_ext >= VS_START) && (w_v_ext < VS_END));
      r_frame_tick <= r_pix_en && (w_h_next == 10'd0) && (w_v_next == V_TICK);
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic r_hsync_d;
  logic r_vsync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hsync_d <= 1'b1;
      r_vsync_d <= 1'b1;
    end else if (r_pix_en) begin
      r_hsync_d <= r_hsync;
      r_vsync_d <= r_vsync;
    end
  end

  assign hSync = r_hsync_d;
  assign vSync = r_vsync_d;
`else
  assign hSync = r_hsync;
  assign vSync = r_vsync;
`endif

  assign pix_en     = r_pix_en;
  assign hCount     = r_h;
  assign vCount     = r_v;
  assign bright     = r_bright;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for reset/line/mid-sync reset,
// small-geometry instance (16x13 pixels, CLK_DIV=2) for frame, vSync, frame_tick and wrap.
module tb_vga_timing_gen;

  logic       clk;
  logic       reset;

  logic       d_pix, d_bright, d_hs, d_vs, d_ft;
  logic [9:0] d_h, d_v;
  logic       s_pix, s_bright, s_hs, s_vs, s_ft;
  logic [9:0] s_h, s_v;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [24:0] D_RST = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  vga_timing_gen u_dut (
    .clk(clk), .reset(reset), .pix_en(d_pix), .hCount(d_h), .vCount(d_v),
    .bright(d_bright), .hSync(d_hs), .vSync(d_vs), .frame_tick(d_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en(s_pix), .hCount(s_h), .vCount(s_v),
    .bright(s_bright), .hSync(s_hs), .vSync(s_vs), .frame_tick(s_ft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] d_state();
    return {d_h, d_v, d_bright, d_hs, d_vs, d_pix, d_ft};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] exp_tab [8];
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_state() !== D_RST) $display("FAIL reset_hold: got %h expected %h", d_state(), D_RST);
    else n_pass++;
    reset = 1'b1;
    // After release: div_cnt 1,2,3 (pix_en high on 3), wrap to (0,0) on the 4th edge
    exp_tab[0] = D_RST;
    exp_tab[1] = D_RST;
    exp_tab[2] = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_tab[3] = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_tab[4] = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_tab[5] = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_tab[6] = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_tab[7] = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_state() !== exp_tab[i])
        $display("FAIL release_cycle%0d: got %h expected %h", i + 1, d_state(), exp_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_line();
    int k = 0;
    int hs_cnt = 0, br_cnt = 0, pix_cnt = 0, v_bad = 0;
    int hs_first = -1, hs_last = -1, br_fall = -1;
    do_reset();
    while (d_h !== 10'd0 && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (d_h !== 10'd0) $display("FAIL line_start_timeout: got h=%0d expected 0", d_h);
    else n_pass++;
    for (int i = 0; i < 3200; i++) begin
      if (d_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_h);
        hs_last = int'(d_h);
      end
      if (d_bright === 1'b1) br_cnt++;
      else if (br_fall < 0) br_fall = int'(d_h);
      if (d_pix === 1'b1) pix_cnt++;
      if (d_v !== 10'd0) v_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (hs_cnt != 384) $display("FAIL hsync_width: got %0d clk expected 384", hs_cnt); else n_pass++;
    n_checks++;
    if (hs_first != 656) $display("FAIL hsync_start: got h=%0d expected 656", hs_first); else n_pass++;
    n_checks++;
    if (hs_last != 751) $display("FAIL hsync_end: got h=%0d expected 751", hs_last); else n_pass++;
    n_checks++;
    if (br_fall != 640) $display("FAIL bright_fall: got h=%0d expected 640", br_fall); else n_pass++;
    n_checks++;
    if (br_cnt != 2560) $display("FAIL bright_width: got %0d clk expected 2560", br_cnt); else n_pass++;
    n_checks++;
    if (pix_cnt != 800) $display("FAIL pix_en_per_line: got %0d expected 800", pix_cnt); else n_pass++;
    n_checks++;
    if (v_bad != 0) $display("FAIL vcount_in_line: got %0d bad samples expected 0", v_bad); else n_pass++;
    n_checks++;
    if ({d_h, d_v} !== {10'd0, 10'd1})
      $display("FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", d_h, d_v);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sync();
    int k = 0;
    while (d_h !== 10'd700 && k < 4000) begin @(negedge clk); k++; end
    n_checks++;
    if (d_h !== 10'd700 || d_hs !== 1'b0)
      $display("FAIL mid_sync_reach: got h=%0d hs=%b expected h=700 hs=0", d_h, d_hs);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (d_state() !== D_RST) $display("FAIL async_reset: got %h expected %h", d_state(), D_RST);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (d_state() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL restart_after_reset: got %h expected %h", d_state(),
               {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_frame();
    int k = 0;
    int tick_cnt = 0, vs_cnt = 0, br_cnt = 0, pix_cnt = 0;
    int tick_h = -1, tick_v = -1, vs_min = -1, vs_max = -1;
    do_reset();
    while ({s_h, s_v} !== 20'd0 && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if ({s_h, s_v} !== 20'd0) $display("FAIL frame_start_timeout: got h=%0d v=%0d expected 0,0", s_h, s_v);
    else n_pass++;
    // Small geometry: 16 px/line, 13 lines, 2 clk/px -> 416 clk per frame
    for (int i = 0; i < 416; i++) begin
      if (s_ft === 1'b1) begin
        tick_cnt++;
        tick_h = int'(s_h);
        tick_v = int'(s_v);
      end
      if (s_vs === 1'b0) begin
        vs_cnt++;
        if (vs_min < 0) vs_min = int'(s_v);
        vs_max = int'(s_v);
      end
      if (s_bright === 1'b1) br_cnt++;
      if (s_pix === 1'b1) pix_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (tick_cnt != 1) $display("FAIL frame_tick_count: got %0d expected 1", tick_cnt); else n_pass++;
    n_checks++;
    if (tick_h != 0 || tick_v != 6)
      $display("FAIL frame_tick_pos: got h=%0d v=%0d expected h=0 v=6", tick_h, tick_v);
    else n_pass++;
    n_checks++;
    if (vs_cnt != 64) $display("FAIL vsync_width: got %0d clk expected 64", vs_cnt); else n_pass++;
    n_checks++;
    if (vs_min != 8 || vs_max != 9)
      $display("FAIL vsync_lines: got %0d..%0d expected 8..9", vs_min, vs_max);
    else n_pass++;
    n_checks++;
    if (br_cnt != 96) $display("FAIL frame_bright: got %0d clk expected 96", br_cnt); else n_pass++;
    n_checks++;
    if (pix_cnt != 208) $display("FAIL frame_pix_en: got %0d expected 208", pix_cnt); else n_pass++;
    n_checks++;
    if ({s_h, s_v} !== 20'd0) $display("FAIL frame_length: got h=%0d v=%0d expected 0,0", s_h, s_v);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int k = 0;
    while ({s_h, s_v} !== {10'd15, 10'd12} && k < 500) begin @(negedge clk); k++; end
    n_checks++;
    if ({s_h, s_v, s_bright, s_hs, s_vs} !== {10'd15, 10'd12, 1'b0, 1'b1, 1'b1})
      $display("FAIL pre_wrap: got h=%0d v=%0d br=%b hs=%b vs=%b expected 15,12,0,1,1",
               s_h, s_v, s_bright, s_hs, s_vs);
    else n_pass++;
    k = 0;
    while (s_h === 10'd15 && k < 5) begin @(negedge clk); k++; end
    n_checks++;
    if ({s_h, s_v, s_bright, s_hs, s_vs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL post_wrap: got h=%0d v=%0d br=%b hs=%b vs=%b expected 0,0,1,1,1",
               s_h, s_v, s_bright, s_hs, s_vs);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_line();
    test_reset_mid_sync();
    test_frame();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the 640x480@60 Hz VGA path. Divides the 100 MHz system clock into a pixel-rate enable, runs the horizontal and vertical pixel counters, and produces the sync pulses. It drives `hCount`, `vCount` and `bright` into `vga_bitchange`, which turns them into `rgb`. It also emits a once-per-frame tick at the start of vertical blank, which game logic uses for physics and scroll updates.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; must be ≥2.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VIS`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: asynchronous, active-low reset.
- `pix_en`  out  1: one-`clk` pulse per pixel period.
- `hCount`  out  10: horizontal pixel index, 0..H_TOTAL-1.
- `vCount`  out  10: vertical line index, 0..V_TOTAL-1.
- `bright`  out  1: high when hCount<H_VIS and vCount<V_VIS.
- `hSync`  out  1: horizontal sync, active low.
- `vSync`  out  1: vertical sync, active low.
- `frame_tick`  out  1: one-`clk` pulse at the start of vertical blank.

## Operation
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1, then wraps.
  - `pix_en` is high exactly when `div_cnt`==CLK_DIV-1.
- Counters advance only on `clk` edges where `pix_en` is high:
  - `hCount` increments; at H_TOTAL-1 it wraps to 0.
  - On the `hCount` wrap, `vCount` increments; at V_TOTAL-1 it wraps to 0.
  - Both wrap on the same edge at (H_TOTAL-1, V_TOTAL-1) → (0,0).
- Decodes are evaluated on the next counter values and registered on the same edge, so they always agree with the `hCount`/`vCount` currently presented:
  - `bright` = (h<H_VIS) && (v<V_VIS).
  - `hSync` low iff H_VIS+H_FP ≤ h < H_VIS+H_FP+H_SYNC, i.e. 656..751.
  - `vSync` low iff V_VIS+V_FP ≤ v < V_VIS+V_FP+V_SYNC, i.e. 490..491.
- `frame_tick` is high for exactly one `clk`: the cycle after the edge on which the counters become (0, V_VIS). One tick per frame.
- Width rules: counters are 10 bits, and H_TOTAL and V_TOTAL must be ≤1024. Wrap detection uses equality with TOTAL-1, never overflow.

## Timing
- Reset (asynchronous assert, `reset`=0) forces:
  - `div_cnt`=0, `hCount`=H_TOTAL-1 (799), `vCount`=V_TOTAL-1 (524);
  - `bright`=0, `hSync`=1, `vSync`=1, `pix_en`=0, `frame_tick`=0.
- Release is sampled on the rising `clk` edge. The first `pix_en` comes CLK_DIV cycles after release; on that edge the counters go to (0,0) and `bright` goes to 1.
- All outputs are registered, with no combinational path from input to output.
- Pixel period is CLK_DIV `clk` cycles. A line is H_TOTAL×CLK_DIV = 3200 `clk` cycles; a frame is 525 lines = 1,680,000 `clk` cycles.
- Reset asserted mid-line or mid-sync takes effect immediately:
  - outputs return to reset values with no partial sync pulse held;
  - after release, timing restarts cleanly at (0,0).

## Configuration
- `VGA_SYNC_DELAY_EN`:
  - Defined: `hSync` and `vSync` pass through one extra register stage, loaded only on `pix_en`, so they lag `hCount`/`vCount`/`bright` by one pixel period. This matches the one-clock registered sprite ROM read downstream. The stage resets to 1.
  - Undefined: syncs are aligned with the counters exactly as in Operation.
  - `bright`, `frame_tick` and `pix_en` are unaffected either way.

## Test plan
- Reset hold, then release → outputs at reset values; after 4 `clk` cycles, first `pix_en` with (h,v)=(0,0), `bright`=1, `hSync`=`vSync`=1.
- One line → `hSync` low for exactly 96 pixels (384 `clk`) starting at h=656; `bright` falls at h=640; h wraps 799→0 and v increments.
- Full frame → `vSync` low during v=490..491 (2 lines, 6400 `clk`); exactly one `frame_tick`, at v=480 h=0; frame length 1,680,000 `clk`.
- Counter wrap → on the edge from (799,524) to (0,0), `vCount` and `hCount` wrap together; `bright` goes to 1.
- Reset asserted at h=700 (inside `hSync`) → `hSync` returns to 1 asynchronously, counters go to (799,524); clean restart after release.
- With `VGA_SYNC_DELAY_EN` defined → `hSync` falls at h=657, not 656; `vSync` low during the 2 lines starting at pixel (0,490)+1 pixel; `bright` timing unchanged.
